uvmt_cv32e40x_obi_mem_slave: RTL and testbench
==============================================

UVMT_CV32E40X_OBI_MEM_SLAVE -- requirements
Module: uvmt_cv32e40x_obi_mem_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning OBI data width in bits (32 or 64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning OBI byte-address width.
REQ-003 SHALL have parameter DEPTH, default 1024, meaning memory size in DATA_WIDTH words (power of 2).
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, meaning response FIFO depth (1..8).
REQ-005 SHALL have parameter GNT_DELAY, default 0, meaning cycles req_i waits before gnt_o (0..15).
REQ-006 SHALL have parameter RVALID_DELAY, default 1, meaning minimum cycles from grant to rvalid_o (1..15).
REQ-007 SHALL have parameter FLUSH_DELAY, default 2, meaning cycles fencei_flush_req_i is held before ack (1..15).
REQ-008 clk_i  input  1  sole clock; all state changes on rising edge.
REQ-009 rst_i  input  1  reset, asynchronous, active-high.
REQ-010 req_i  input  1  OBI address-phase request.
REQ-011 gnt_o  output  1  OBI grant.
REQ-012 addr_i  input  ADDR_WIDTH  byte address.
REQ-013 we_i  input  1  1 = write, 0 = read.
REQ-014 be_i  input  DATA_WIDTH/8  byte enables.
REQ-015 wdata_i  input  DATA_WIDTH  write data.
REQ-016 rvalid_o  output  1  OBI response valid; no rready, always accepted.
REQ-017 rdata_o  output  DATA_WIDTH  read data, valid with rvalid_o.
REQ-018 err_o  output  1  response error, valid with rvalid_o.
REQ-019 fencei_flush_req_i  input  1  fence.i flush request.
REQ-020 fencei_flush_ack_o  output  1  fence.i flush acknowledge.

Function
REQ-021 Word index SHALL be addr_i[LSB +: log2(DEPTH)], LSB = log2(DATA_WIDTH/8); address out of range when addr_i >> LSB >= DEPTH.
REQ-022 Wait counter SHALL count cycles with req_i=1 and no grant, saturating at GNT_DELAY; cleared on grant or req_i=0.
REQ-023 gnt_o SHALL be combinational: req_i & (wait counter == GNT_DELAY) & (FIFO count < MAX_OUTSTANDING); GNT_DELAY=0 gives same-cycle grant.
REQ-024 Full FIFO SHALL block grant even if a pop occurs that cycle (no bypass).
REQ-025 On grant of an in-range write, bytes with be_i set SHALL be written at that edge; others unchanged; out-of-range writes SHALL not modify memory.
REQ-026 On grant, one entry SHALL be pushed: rdata = memory word at grant (reads, in range) else 0; err = out-of-range; age = 0.
REQ-027 Every FIFO entry age SHALL increment each cycle, saturating at 15.
REQ-028 rvalid_o SHALL be 1 exactly when FIFO non-empty and head age >= RVALID_DELAY-1 (earliest rvalid cycle after grant = RVALID_DELAY); head pops that cycle.
REQ-029 Responses SHALL be in grant order, at most one per cycle; rdata_o/err_o SHALL be 0 when rvalid_o=0.
REQ-030 Simultaneous push and pop SHALL leave count unchanged; read granted the cycle after a write to the same word SHALL return the new data.
REQ-031 Flush counter SHALL count cycles with fencei_flush_req_i=1, saturating at FLUSH_DELAY; cleared when fencei_flush_req_i=0.
REQ-032 fencei_flush_ack_o SHALL pulse one cycle when flush counter == FLUSH_DELAY, FIFO empty and ack not yet given for this request; no further ack until fencei_flush_req_i deasserts.
REQ-033 Non-empty FIFO SHALL hold off ack; ack then follows the cycle after the FIFO drains.

Reset
REQ-034 While rst_i=1: gnt_o, rvalid_o, err_o, fencei_flush_ack_o = 0, rdata_o = 0, FIFO empty, all counters 0.
REQ-035 Memory contents SHALL not be reset; reset mid-transaction SHALL discard all queued responses, none emitted after release.

Verification
REQ-036 Defaults: write 0xDEADBEEF be=0xF to 0x10, then read 0x10 -> gnt same cycle as req, rvalid 1 cycle after each grant, rdata 0xDEADBEEF.
REQ-037 Write 0xFFFFFFFF, then 0x00000000 be=0x3 to 0x20, read -> rdata 0xFFFF0000.
REQ-038 MAX_OUTSTANDING=2, RVALID_DELAY=4, req held 4 cycles -> exactly 2 grants, third grant only after first rvalid, responses in order.
REQ-039 Read addr 4*DEPTH -> err_o=1, rdata_o=0; memory unchanged on out-of-range write.
REQ-040 FLUSH_DELAY=2, flush req with 1 response pending -> ack one cycle after FIFO drains, single pulse while req held.
REQ-041 Assert rst_i with 2 entries queued -> rvalid_o=0 immediately and after release; prior memory data still readable.

Source files
------------

// File: rtl/uvmt_cv32e40x_obi_mem_slave.sv
// OBI memory slave with programmable grant/response latency and
// fence.i flush handshake; responses queue in a shifting FIFO.
module uvmt_cv32e40x_obi_mem_slave #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int DEPTH           = 1024,
    parameter int MAX_OUTSTANDING = 2,
    parameter int GNT_DELAY       = 0,
    parameter int RVALID_DELAY    = 1,
    parameter int FLUSH_DELAY     = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    input  logic                    fencei_flush_req_i,
    output logic                    fencei_flush_ack_o
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW  = $clog2(DEPTH);
    localparam int MO  = MAX_OUTSTANDING;

    localparam logic [3:0] GD   = 4'(GNT_DELAY);
    localparam logic [3:0] RD   = 4'(RVALID_DELAY - 1);
    localparam logic [3:0] FD   = 4'(FLUSH_DELAY);
    localparam logic [3:0] MO_L = 4'(MAX_OUTSTANDING);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [3:0]            wcnt_q, wcnt_d;
    logic [3:0]            fcnt_q, fcnt_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  acked_q, acked_d;
    logic [DATA_WIDTH-1:0] frd_q [MO];
    logic [DATA_WIDTH-1:0] frd_d [MO];
    logic                  ferr_q [MO];
    logic                  ferr_d [MO];
    logic [3:0]            fage_q [MO];
    logic [3:0]            fage_d [MO];

    logic [IW-1:0]         idx;
    logic                  oor;
    logic                  gnt;
    logic                  pop;
    logic                  ack;
    logic [3:0]            wp;
    logic [DATA_WIDTH-1:0] push_rd;

    function automatic logic [3:0] sat_inc(input logic [3:0] a);
        return (a == 4'hF) ? a : a + 4'd1;
    endfunction

    assign idx = addr_i[LSB +: IW];
    assign oor = (addr_i >> (LSB + IW)) != '0;

    assign gnt = !rst_i && req_i && (wcnt_q == GD) && (cnt_q < MO_L);
    assign pop = !rst_i && (cnt_q != 4'd0) && (fage_q[0] >= RD);
    assign ack = !rst_i && fencei_flush_req_i && (fcnt_q == FD)
                 && (cnt_q == 4'd0) && !acked_q;

    assign gnt_o              = gnt;
    assign rvalid_o           = pop;
    assign rdata_o            = pop ? frd_q[0] : '0;
    assign err_o              = pop && ferr_q[0];
    assign fencei_flush_ack_o = ack;

    assign push_rd = (we_i || oor) ? '0 : mem_q[idx];
    assign wp      = pop ? cnt_q - 4'd1 : cnt_q;

    always_comb begin
        wcnt_d = wcnt_q;
        if (!req_i || gnt) begin
            wcnt_d = 4'd0;
        end else if (wcnt_q != GD) begin
            wcnt_d = wcnt_q + 4'd1;
        end

        fcnt_d = 4'd0;
        if (fencei_flush_req_i) begin
            fcnt_d = (fcnt_q == FD) ? fcnt_q : fcnt_q + 4'd1;
        end
        acked_d = fencei_flush_req_i && (acked_q || ack);

        cnt_d = cnt_q + {3'b000, gnt} - {3'b000, pop};
    end

    // Head is always slot 0; a pop shifts every entry down one slot.
    always_comb begin
        for (int i = 0; i < MO; i++) begin
            frd_d[i]  = frd_q[i];
            ferr_d[i] = ferr_q[i];
            fage_d[i] = sat_inc(fage_q[i]);
        end
        if (pop) begin
            for (int i = 0; i < MO - 1; i++) begin
                frd_d[i]  = frd_q[i+1];
                ferr_d[i] = ferr_q[i+1];
                fage_d[i] = sat_inc(fage_q[i+1]);
            end
        end
        for (int i = 0; i < MO; i++) begin
            if (gnt && (4'(i) == wp)) begin
                frd_d[i]  = push_rd;
                ferr_d[i] = oor;
                fage_d[i] = 4'd0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wcnt_q  <= 4'd0;
            fcnt_q  <= 4'd0;
            cnt_q   <= 4'd0;
            acked_q <= 1'b0;
            for (int i = 0; i < MO; i++) begin
                frd_q[i]  <= '0;
                ferr_q[i] <= 1'b0;
                fage_q[i] <= 4'd0;
            end
        end else begin
            wcnt_q  <= wcnt_d;
            fcnt_q  <= fcnt_d;
            cnt_q   <= cnt_d;
            acked_q <= acked_d;
            for (int i = 0; i < MO; i++) begin
                frd_q[i]  <= frd_d[i];
                ferr_q[i] <= ferr_d[i];
                fage_q[i] <= fage_d[i];
            end
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk_i) begin
        if (gnt && we_i && !oor) begin
            for (int b = 0; b < NB; b++) begin
                if (be_i[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_uvmt_cv32e40x_obi_mem_slave.sv
// Directed bench: default instance plus a RVALID_DELAY=4 instance.
module tb_uvmt_cv32e40x_obi_mem_slave;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req1, we1, flush1, gnt1, rvalid1, err1, ack1;
    logic [31:0] addr1, wdata1, rdata1;
    logic [3:0]  be1;
    logic        req2, we2, flush2, gnt2, rvalid2, err2, ack2;
    logic [31:0] addr2, wdata2, rdata2;
    logic [3:0]  be2;

    uvmt_cv32e40x_obi_mem_slave u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .gnt_o(gnt1),
        .addr_i(addr1), .we_i(we1), .be_i(be1), .wdata_i(wdata1),
        .rvalid_o(rvalid1), .rdata_o(rdata1), .err_o(err1),
        .fencei_flush_req_i(flush1), .fencei_flush_ack_o(ack1)
    );

    uvmt_cv32e40x_obi_mem_slave #(.RVALID_DELAY(4)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .req_i(req2), .gnt_o(gnt2),
        .addr_i(addr2), .we_i(we2), .be_i(be2), .wdata_i(wdata2),
        .rvalid_o(rvalid2), .rdata_o(rdata2), .err_o(err2),
        .fencei_flush_req_i(flush2), .fencei_flush_ack_o(ack2)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic xact1(input string tag, input logic we,
                         input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] erd,
                         input logic eerr);
        req1 = 1'b1; we1 = we; addr1 = a; be1 = be; wdata1 = wd;
        @(negedge clk);
        check({tag, ".gnt"}, gnt1, 1);
        step;
        req1 = 1'b0; we1 = 1'b0;
        @(negedge clk);
        check({tag, ".rvalid"}, rvalid1, 1);
        check({tag, ".rdata"}, rdata1, erd);
        check({tag, ".err"}, err1, eerr);
        step;
    endtask

    task automatic write2(input logic [31:0] a, input logic [31:0] d);
        req2 = 1'b1; we2 = 1'b1; addr2 = a; be2 = 4'hF; wdata2 = d;
        @(negedge clk);
        check("w2.gnt", gnt2, 1);
        step;
        req2 = 1'b0; we2 = 1'b0;
        repeat (6) step;
    endtask

    localparam logic [31:0] D0 = 32'h1111_1111;
    localparam logic [31:0] D1 = 32'h2222_2222;
    localparam logic [31:0] D2 = 32'h3333_3333;

    logic        eg  [10] = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 0};
    logic        erv [10] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 1};
    logic [31:0] ed  [10] = '{0, 0, 0, 0, D0, D1, 0, 0, 0, D2};

    initial begin
        int ng;
        logic g;
        rst = 1'b1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h10; be1 = 4'hF; wdata1 = '0;
        flush1 = 1'b0;
        req2 = 1'b0; we2 = 1'b0; addr2 = '0; be2 = 4'hF; wdata2 = '0;
        flush2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.gnt", gnt1, 0);
        check("rst.rvalid", rvalid1, 0);
        check("rst.rdata", rdata1, 0);
        check("rst.err", err1, 0);
        check("rst.ack", ack1, 0);
        step;
        rst = 1'b0; req1 = 1'b0;
        step;

        xact1("wr10", 1, 32'h10, 4'hF, 32'hDEAD_BEEF, 0, 0);
        xact1("rd10", 0, 32'h10, 4'hF, 0, 32'hDEAD_BEEF, 0);

        xact1("wr20a", 1, 32'h20, 4'hF, 32'hFFFF_FFFF, 0, 0);
        xact1("wr20b", 1, 32'h20, 4'h3, 32'h0000_0000, 0, 0);
        xact1("rd20", 0, 32'h20, 4'hF, 0, 32'hFFFF_0000, 0);

        xact1("wr0", 1, 32'h0, 4'hF, 32'hA5A5_A5A5, 0, 0);
        xact1("rdoor", 0, 32'h1000, 4'hF, 0, 0, 1);
        xact1("wroor", 1, 32'h1000, 4'hF, 32'h1234_5678, 0, 1);
        xact1("rd0", 0, 32'h0, 4'hF, 0, 32'hA5A5_A5A5, 0);

        // Write then same-word read on the next cycle.
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h30; be1 = 4'hF;
        wdata1 = 32'h0BAD_F00D;
        @(negedge clk);
        check("b2b.wgnt", gnt1, 1);
        step;
        we1 = 1'b0;
        @(negedge clk);
        check("b2b.rgnt", gnt1, 1);
        check("b2b.wrvalid", rvalid1, 1);
        check("b2b.wrdata", rdata1, 0);
        step;
        req1 = 1'b0;
        @(negedge clk);
        check("b2b.rrvalid", rvalid1, 1);
        check("b2b.rrdata", rdata1, 32'h0BAD_F00D);
        step;
        @(negedge clk);
        check("b2b.idle", rvalid1, 0);
        step;

        flush1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("fl1.ack%0d", i), ack1, (i == 2));
            step;
        end
        flush1 = 1'b0;
        step;

        write2(32'h0, D0);
        write2(32'h4, D1);
        write2(32'h8, D2);

        ng = 0;
        req2 = 1'b1; addr2 = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            g = gnt2;
            check($sformatf("os.gnt%0d", i), gnt2, eg[i]);
            check($sformatf("os.rv%0d", i), rvalid2, erv[i]);
            check($sformatf("os.rd%0d", i), rdata2, ed[i]);
            step;
            if (g) begin
                ng++;
                addr2 = 32'(ng * 4);
                if (ng == 3) req2 = 1'b0;
            end
        end
        req2 = 1'b0;
        repeat (2) step;

        req2 = 1'b1; addr2 = 32'h4; flush2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) check("fl2.gnt", gnt2, 1);
            check($sformatf("fl2.ack%0d", i), ack2, (i == 5));
            check($sformatf("fl2.rv%0d", i), rvalid2, (i == 4));
            step;
            req2 = 1'b0;
        end
        flush2 = 1'b0;
        step;

        req2 = 1'b1; addr2 = 32'h0;
        step;
        addr2 = 32'h4;
        step;
        req2 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst2.rv", rvalid2, 0);
        step;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("rst2.post%0d", i), rvalid2, 0);
            step;
        end

        req2 = 1'b1; addr2 = 32'h0;
        @(negedge clk);
        check("rst2.gnt", gnt2, 1);
        step;
        req2 = 1'b0;
        repeat (3) step;
        @(negedge clk);
        check("rst2.rv", rvalid2, 1);
        check("rst2.rd", rdata2, D0);
        step;
        xact1("rst1.rd10", 0, 32'h10, 4'hF, 0, 32'hDEAD_BEEF, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
